// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I field bundles into instruction words behind a 2-entry skid buffer.
// Optional legality checking (NOP substitution plus err output) is enabled by defining INSTR_ENC_CHECK_EN.

module instr_encoder #(
    parameter int unsigned       WIDTH     = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_instr,
`ifdef INSTR_ENC_CHECK_EN
    output logic              err,
`endif
    output logic [ADDR_W-1:0] out_addr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [WIDTH-1:0]   out_instr_q, out_instr_d;
    logic [WIDTH-1:0]   skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
    logic [31:0]        enc;
    logic [WIDTH-1:0]   word;
    logic               accept;
    logic               emit;

    // Reserved formats fall through to the R layout.
    always_comb begin
        enc = {funct7, rs2, rs1, funct3, rd, opcode};
        case (fmt_e'(fmt))
            FMT_I: enc = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: enc = {imm[31:12], rd, opcode};
            FMT_J: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: ;
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    logic illegal;
    logic err_q, err_d;
    logic skid_err_q, skid_err_d;

    // Range checks: upper immediate bits must all equal the sign bit.
    always_comb begin
        illegal = 1'b0;
        case (fmt_e'(fmt))
            FMT_R: illegal = 1'b0;
            FMT_I, FMT_S: illegal = !((imm[31:11] == '0) || (imm[31:11] == '1));
            FMT_B: illegal = !((imm[31:12] == '0) || (imm[31:12] == '1)) || imm[0];
            FMT_J: illegal = !((imm[31:20] == '0) || (imm[31:20] == '1)) || imm[0];
            FMT_U: illegal = (imm[11:0] != '0);
            default: illegal = 1'b1;
        endcase
    end

    assign word = illegal ? WIDTH'(NOP) : WIDTH'(enc);
`else
    assign word = WIDTH'(enc);
`endif

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign emit      = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        out_instr_d  = out_instr_q;
        skid_instr_d = skid_instr_q;
        out_addr_d   = out_addr_q;
`ifdef INSTR_ENC_CHECK_EN
        err_d        = err_q;
        skid_err_d   = skid_err_q;
`endif
        if (flush) begin
            state_d      = EMPTY;
            out_instr_d  = '0;
            skid_instr_d = '0;
            out_addr_d   = BASE_ADDR;
`ifdef INSTR_ENC_CHECK_EN
            err_d        = 1'b0;
            skid_err_d   = 1'b0;
`endif
        end else begin
            if (emit) begin
                out_addr_d = out_addr_q + ADDR_W'(4);
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        out_instr_d = word;
`ifdef INSTR_ENC_CHECK_EN
                        err_d       = illegal;
`endif
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        state_d      = TWO;
                        skid_instr_d = word;
`ifdef INSTR_ENC_CHECK_EN
                        skid_err_d   = illegal;
`endif
                    end else if (emit && !accept) begin
                        state_d = EMPTY;
                    end else if (emit && accept) begin
                        out_instr_d = word;
`ifdef INSTR_ENC_CHECK_EN
                        err_d       = illegal;
`endif
                    end
                end
                TWO: begin
                    if (emit) begin
                        state_d     = ONE;
                        out_instr_d = skid_instr_q;
`ifdef INSTR_ENC_CHECK_EN
                        err_d       = skid_err_q;
`endif
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_instr_q  <= '0;
            skid_instr_q <= '0;
            out_addr_q   <= BASE_ADDR;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_instr_q  <= out_instr_d;
            skid_instr_q <= skid_instr_d;
            out_addr_q   <= out_addr_d;
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            skid_err_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            skid_err_q <= skid_err_d;
        end
    end

    assign err = err_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: arithmetic reference model, FIFO of expected words,
// independent monitor checking emitted words and addresses (8-bit address to exercise wrap).

module tb_instr_encoder;

    localparam int unsigned       AW   = 8;
    localparam logic [AW-1:0]     BASE = 8'hF0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    fmt = '0;
    logic [6:0]    opcode = '0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]    funct3 = '0;
    logic [6:0]    funct7 = '0;
    logic [31:0]   imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
`ifdef INSTR_ENC_CHECK_EN
    logic          err;
`endif

    instr_encoder #(.WIDTH(32), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr),
`ifdef INSTR_ENC_CHECK_EN
        .err(err),
`endif
        .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_instr(input bundle_t b);
        logic [31:0] op = 32'(b.op);
        logic [31:0] d  = 32'(b.rd) << 7;
        logic [31:0] f3 = 32'(b.f3) << 12;
        logic [31:0] r1 = 32'(b.rs1) << 15;
        logic [31:0] r2 = 32'(b.rs2) << 20;
        logic [31:0] i  = b.imm;
        case (b.fmt)
            3'd1: return op | d | f3 | r1 | ((i & 32'hFFF) << 20);
            3'd2: return op | ((i & 32'h1F) << 7) | f3 | r1 | r2 | (((i >> 5) & 32'h7F) << 25);
            3'd3: return op | (((i >> 11) & 32'h1) << 7) | (((i >> 1) & 32'hF) << 8) | f3 | r1 | r2
                         | (((i >> 5) & 32'h3F) << 25) | (((i >> 12) & 32'h1) << 31);
            3'd4: return op | d | (i & 32'hFFFFF000);
            3'd5: return op | d | (((i >> 12) & 32'hFF) << 12) | (((i >> 11) & 32'h1) << 20)
                         | (((i >> 1) & 32'h3FF) << 21) | (((i >> 20) & 32'h1) << 31);
            default: return op | d | f3 | r1 | r2 | (32'(b.f7) << 25);
        endcase
    endfunction

`ifdef INSTR_ENC_CHECK_EN
    function automatic bit model_illegal(input bundle_t b);
        int s = $signed(b.imm);
        case (b.fmt)
            3'd0: return 1'b0;
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3: return (s < -4096) || (s > 4094) || (s % 2 != 0);
            3'd4: return (s % 4096) != 0;
            3'd5: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
            default: return 1'b1;
        endcase
    endfunction
`endif

    function automatic bundle_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                   input logic [4:0] a, input logic [4:0] b2, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [31:0] i);
        bundle_t r;
        r.fmt = f; r.op = op; r.rd = d; r.rs1 = a; r.rs2 = b2; r.f3 = f3; r.f7 = f7; r.imm = i;
        return r;
    endfunction

    function automatic exp_t ex(input logic [31:0] instr, input logic e);
        exp_t r;
        r.instr = instr; r.err = e;
        return r;
    endfunction

    task automatic drive(input bundle_t b);
        fmt = b.fmt; opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
        funct3 = b.f3; funct7 = b.f7; imm = b.imm;
    endtask

    // Called at every falling edge: occupancy of the scoreboard predicts the handshake outputs.
    task automatic step();
        check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            step();
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input bundle_t b, input exp_t e);
        int unsigned waited = 0;
        @(negedge clk);
        step();
        drive(b);
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            step();
            waited++;
        end
        if (in_ready) begin
            sb.push_back(e);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0, required 1 within 50 cycles");
            in_valid = 1'b0;
        end
    endtask

    task automatic send_model(input bundle_t b);
        exp_t e;
        e.instr = model_instr(b);
        e.err   = 1'b0;
`ifdef INSTR_ENC_CHECK_EN
        if (model_illegal(b)) begin
            e.instr = 32'h0000_0013;
            e.err   = 1'b1;
        end
`endif
        send(b, e);
    endtask

    // Monitor: samples just before the rising edge, pops on every emit.
    initial begin
        int unsigned idx = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n || flush) begin
                idx = 0;
            end else if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL emit_unexpected: got %h, required no output", out_instr);
                end else begin
                    e = sb.pop_front();
                    check("emit_instr", out_instr, e.instr);
                    check("emit_addr", 32'(out_addr), 32'(AW'(32'(BASE) + 4 * idx)));
`ifdef INSTR_ENC_CHECK_EN
                    check("emit_err", 32'(err), 32'(e.err));
`endif
                    idx++;
                end
            end
        end
    end

    initial begin
        bundle_t b;
        int unsigned waited;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'(BASE));
`ifdef INSTR_ENC_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Reference vectors with hand-computed encodings.
        send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), ex(32'h00500093, 1'b0));
        send(mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0), ex(32'h002081B3, 1'b0));
        send(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), ex(32'h0020A423, 1'b0));
        send(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4), ex(32'hFE000EE3, 1'b0));
        send(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000), ex(32'h123452B7, 1'b0));
        idle(2);

        // Backpressure: two accepted, third held off until the consumer releases.
        out_ready = 1'b0;
        send(mk(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd1), ex(32'h00118113, 1'b0));
        send(mk(3'd1, 7'h13, 5'd4, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2), ex(32'h00218213, 1'b0));
        @(negedge clk);
        step();
        b = mk(3'd1, 7'h13, 5'd6, 5'd3, 5'd0, 3'd0, 7'd0, 32'd3);
        drive(b);
        in_valid = 1'b1;
        idle(0);
        repeat (2) begin
            @(negedge clk);
            step();
        end
        out_ready = 1'b1;
        send(b, ex(32'h00318313, 1'b0));
        idle(4);

        // Flush with two items buffered and a valid bundle on the input.
        out_ready = 1'b0;
        send(mk(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0), ex(32'h003100B3, 1'b0));
        send(mk(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0), ex(32'h00628233, 1'b0));
        @(negedge clk);
        step();
        flush = 1'b1;
        in_valid = 1'b1;
        sb.delete();
        @(negedge clk);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_addr", 32'(out_addr), 32'(BASE));
        out_ready = 1'b1;
        send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), ex(32'h00500093, 1'b0));
        idle(3);

        // Asynchronous reset pulse with two items buffered.
        out_ready = 1'b0;
        send(mk(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9), ex(32'h00900393, 1'b0));
        send(mk(3'd1, 7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9), ex(32'h00900413, 1'b0));
        @(negedge clk);
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rstpulse_out_valid", 32'(out_valid), 32'd0);
        check("rstpulse_in_ready", 32'(in_ready), 32'd1);
        check("rstpulse_out_addr", 32'(out_addr), 32'(BASE));
        @(negedge clk);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000), ex(32'h123452B7, 1'b0));
        idle(3);

`ifdef INSTR_ENC_CHECK_EN
        send(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3), ex(32'h00000013, 1'b1));
        send(mk(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0), ex(32'h00000013, 1'b1));
        send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), ex(32'h00500093, 1'b0));
        idle(3);
`endif

        // Randomized traffic with random consumer stalls and input gaps.
        rand_ready = 1'b1;
        for (int unsigned n = 0; n < 400; n++) begin
            b.fmt = 3'($urandom_range(0, 7));
            b.op  = 7'($urandom());
            b.rd  = 5'($urandom());
            b.rs1 = 5'($urandom());
            b.rs2 = 5'($urandom());
            b.f3  = 3'($urandom());
            b.f7  = 7'($urandom());
            case ($urandom_range(0, 2))
                0: b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1: b.imm = $urandom();
                default: b.imm = $urandom() & 32'hFFFFF000;
            endcase
            send_model(b);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        idle(1);
        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            idle(1);
            waited++;
        end
        check("drain_remaining", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
